data_mem_param: RTL and testbench

- Parametrised next-generation data memory for the RV32I core.
- Word-organised block RAM with byte, halfword and word loads/stores, and sign/zero extension on loads.
- Stores are read-modify-write; the pipeline is held through `clk_stall` for every access.
- Adds synchronous reset, configurable depth and MMIO LED register, out-of-range handling, and optional misalignment detection.

---
 rtl/data_mem_param.sv | 201 ++++++++++++++++++++
 tb/tb_data_mem_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_param.sv
// data_mem_param: word-organised data memory for the RV32I core.
// Byte/halfword/word loads and stores with sign/zero extension, an MMIO LED
// register, out-of-range handling and a 2-cycle access (1 cycle of clk_stall).
// Stores are read-modify-write against a synchronous-read RAM.
// Optional misaligned-access detection: define DATA_MEM_MISALIGN_CHECK_EN.

module data_mem_param #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = 32'h2000,
  parameter int unsigned LED_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [3:0]       sign_mask,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] led,
  output logic             clk_stall
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  ,
  output logic             misalign
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StRd, StRmw} state_e;

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] word_buf_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  sm_q;  // {sign-extend, word, halfword}
  logic [31:0] read_data_q;
  logic [31:0] led_q;

  logic          req;
  logic          in_ram, is_led, is_word, is_half, mis_req;
  logic          ram_we, led_we;
  logic [AW-1:0] idx_live, idx_req;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   merged, extracted, load_val;
  logic          unused_sign_mask0;

  assign unused_sign_mask0 = sign_mask[0];

  assign req      = memwrite | memread;
  assign idx_live = addr[AW+1:2];
  assign idx_req  = addr_q[AW+1:2];

  // Decode of the captured request; range check happens before the index is used
  assign in_ram  = (addr_q >> (AW + 2)) == 32'd0;
  assign is_led  = addr_q == LED_ADDR;
  assign is_word = sm_q[1];
  assign is_half = ~sm_q[1] & sm_q[0];

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  assign mis_req = (is_word & (addr_q[1:0] != 2'b00)) | (is_half & addr_q[0]);
`else
  assign mis_req = 1'b0;
`endif

  assign ram_we = (state_q == StRmw) & in_ram & ~is_led & ~mis_req & ~rst;
  assign led_we = (state_q == StRmw) & is_led & is_word & ~mis_req;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every access is fetch then complete; write wins over read
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (memwrite) begin
          state_d = StRmw;
        end else if (memread) begin
          state_d = StRd;
        end
      end
      StRd:    state_d = StIdle;
      StRmw:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the pipeline is held for the single cycle an access is in flight
  always_comb begin
    clk_stall = 1'b0;
    unique case (state_q)
      StIdle:  clk_stall = 1'b0;
      StRd:    clk_stall = 1'b1;
      StRmw:   clk_stall = 1'b1;
      default: clk_stall = 1'b0;
    endcase
  end

  // Store merge: overlay the selected lane(s) of the store data on the fetched word
  always_comb begin
    merged = word_buf_q;
    if (is_word) begin
      merged = wdata_q;
    end else if (is_half) begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q[15:0];
      end else begin
        merged[15:0] = wdata_q[15:0];
      end
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Load extract: pick the lane and zero- or sign-extend it
  always_comb begin
    byte_sel = word_buf_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? word_buf_q[31:16] : word_buf_q[15:0];
    if (is_word) begin
      extracted = word_buf_q;
    end else if (is_half) begin
      extracted = {{16{sm_q[2] & half_sel[15]}}, half_sel};
    end else begin
      extracted = {{24{sm_q[2] & byte_sel[7]}}, byte_sel};
    end
  end

  // Load result selection: misaligned and unmapped addresses read as zero
  always_comb begin
    load_val = 32'd0;
    if (mis_req) begin
      load_val = 32'd0;
    end else if (is_led) begin
      load_val = led_q;
    end else if (in_ram) begin
      load_val = extracted;
    end
  end

  // RAM port: fetch on accept, write back the merged word in the RMW cycle
  always_ff @(posedge clk) begin
    if (state_q == StIdle && req) begin
      word_buf_q <= mem[idx_live];
    end
    if (ram_we) begin
      mem[idx_req] <= merged;
    end
  end

  // Request capture, load result and LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      sm_q        <= 3'd0;
      read_data_q <= 32'd0;
      led_q       <= 32'd0;
    end else begin
      if (state_q == StIdle) begin
        addr_q  <= addr;
        wdata_q <= write_data;
        sm_q    <= sign_mask[3:1];
      end
      if (state_q == StRd) begin
        read_data_q <= load_val;
      end
      if (led_we) begin
        led_q <= wdata_q;
      end
    end
  end

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic mis_q;

  // Sticky misalignment flag, set when a misaligned access completes
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (state_q != StIdle && mis_req) begin
      mis_q <= 1'b1;
    end
  end

  assign misalign = mis_q;
`endif

  assign read_data = read_data_q;
  assign led       = led_q[LED_W-1:0];

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: the stimulus process updates a
// behavioural memory model and queues the expected post-access state; a
// monitor pops it whenever an access completes (clk_stall falls).

module tb_data_mem_param;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] LEDA  = 32'h2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  sign_mask = '0;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        clk_stall;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  data_mem_param #(
    .DEPTH_WORDS(DEPTH),
    .LED_ADDR   (LEDA),
    .LED_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .write_data(write_data),
    .memwrite  (memwrite),
    .memread   (memread),
    .sign_mask (sign_mask),
    .read_data (read_data),
    .led       (led),
    .clk_stall (clk_stall)
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    ,
    .misalign  (misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] led;
    logic        mis;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_rd, m_led;
  logic        m_mis;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mis_model(input logic [31:0] a, input logic [3:0] sm);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if (sm[2]) return (a % 4) != 0;
    if (sm[1]) return (a % 2) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] a, input logic [3:0] sm);
    logic [31:0] w, v;
    if (mis_model(a, sm)) return 32'd0;
    if (a == LEDA) return m_led;
    if (a >= DEPTH * 4) return 32'd0;
    w = ref_mem[a / 4];
    if (sm[2]) return w;
    if (sm[1]) begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sm[3] && v >= 32'h8000) v = v - 32'h10000;
      return v;
    end
    v = (w >> (8 * (a % 4))) & 32'hFF;
    if (sm[3] && v >= 32'h80) v = v - 32'h100;
    return v;
  endfunction

  task automatic store_model(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
    logic [31:0] mask, sh;
    if (mis_model(a, sm)) return;
    if (a == LEDA) begin
      if (sm[2]) m_led = wd;
      return;
    end
    if (a >= DEPTH * 4) return;
    if (sm[2]) begin
      ref_mem[a / 4] = wd;
    end else if (sm[1]) begin
      sh   = 16 * ((a % 4) / 2);
      mask = 32'hFFFF << sh;
      ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | ((wd & 32'hFFFF) << sh);
    end else begin
      sh   = 8 * (a % 4);
      mask = 32'hFF << sh;
      ref_mem[a / 4] = (ref_mem[a / 4] & ~mask) | ((wd & 32'hFF) << sh);
    end
  endtask

  // One request (or one idle cycle); junk is driven while the DUT is busy
  task automatic access(input logic we, input logic re, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sm);
    exp_t e;
    memwrite   = we;
    memread    = re;
    addr       = a;
    write_data = wd;
    sign_mask  = sm;
    @(posedge clk);
    #1;
    if (we || re) begin
      if (mis_model(a, sm)) m_mis = 1'b1;
      if (we) store_model(a, wd, sm);
      else m_rd = load_model(a, sm);
      e.rd  = m_rd;
      e.led = m_led;
      e.mis = m_mis;
      sb_q.push_back(e);
      memwrite   = 1'($urandom);
      memread    = 1'($urandom);
      addr       = $urandom;
      write_data = $urandom;
      sign_mask  = 4'($urandom);
      @(posedge clk);
      #1;
    end
    memwrite = 1'b0;
    memread  = 1'b0;
  endtask

  // Monitor: checks holds every cycle and pops the scoreboard on completion
  initial begin
    logic r;
    logic prev_stall;
    int   stall_len;
    exp_t cur;
    prev_stall = 1'b0;
    stall_len  = 0;
    cur        = '{32'd0, 32'd0, 1'b0};
    forever begin
      @(posedge clk);
      r = rst;
      @(negedge clk);
      if (r) begin
        cur        = '{32'd0, 32'd0, 1'b0};
        stall_len  = 0;
        prev_stall = 1'b0;
        chk("rst_stall", 32'(clk_stall), 32'd0);
      end else if (clk_stall) begin
        stall_len++;
        prev_stall = 1'b1;
        chk("stall_len", 32'(stall_len), 32'd1);
      end else begin
        if (prev_stall) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_empty: access completed, expected none pending at %0t", $time);
          end else begin
            cur = sb_q.pop_front();
          end
        end
        stall_len  = 0;
        prev_stall = 1'b0;
      end
      chk("read_data", read_data, cur.rd);
      chk("led", 32'(led), cur.led & 32'hFF);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
      chk("misalign", 32'(misalign), 32'(cur.mis));
`endif
    end
  end

  initial begin
    logic [31:0] a;
    logic        we, re;
    m_rd  = '0;
    m_led = '0;
    m_mis = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) access(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("idle_rd", read_data, 32'd0);
    chk("idle_stall", 32'(clk_stall), 32'd0);

    // Known contents for the first 16 words
    for (int i = 0; i < 16; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom, 4'b0100);

    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b0100);
    access(1'b0, 1'b1, 32'h10, 32'd0, 4'b0100);
    chk("ld_word", read_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h13, 32'h00000080, 4'b0000);
    access(1'b0, 1'b1, 32'h13, 32'd0, 4'b1000);
    chk("ld_byte_s", read_data, 32'hFFFFFF80);
    access(1'b0, 1'b1, 32'h13, 32'd0, 4'b0000);
    chk("ld_byte_u", read_data, 32'h00000080);
    access(1'b0, 1'b1, 32'h12, 32'd0, 4'b1010);
    chk("ld_half_s", read_data, 32'hFFFF80AD);

    access(1'b1, 1'b0, LEDA, 32'h000000A5, 4'b0100);
    chk("led_set", 32'(led), 32'hA5);
    access(1'b0, 1'b1, LEDA, 32'd0, 4'b0100);
    chk("ld_led", read_data, 32'h000000A5);
    access(1'b0, 1'b1, 32'h0, 32'd0, 4'b0100);
    access(1'b1, 1'b0, LEDA, 32'h0000005A, 4'b0000);  // byte store to LED is dropped

    access(1'b1, 1'b0, 32'h1000, 32'h12345678, 4'b0100);
    access(1'b0, 1'b1, 32'h1000, 32'd0, 4'b0100);
    chk("ld_oor", read_data, 32'd0);
    access(1'b0, 1'b1, 32'h0, 32'd0, 4'b0100);
    access(1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 4'b0100);  // write wins
    access(1'b0, 1'b1, 32'h24, 32'd0, 4'b0100);
    access(1'b1, 1'b0, 32'h21, 32'h11223344, 4'b0100);
    access(1'b0, 1'b1, 32'h20, 32'd0, 4'b0100);

    // Reset during the RMW cycle of a store to 0x20 aborts it
    memwrite   = 1'b1;
    addr       = 32'h20;
    write_data = 32'hA5A5A5A5;
    sign_mask  = 4'b0100;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    memwrite = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_rd  = '0;
    m_led = '0;
    m_mis = 1'b0;
    access(1'b0, 1'b1, 32'h20, 32'd0, 4'b0100);

    // Randomized traffic over RAM window, LED register and unmapped space
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = LEDA;
        1:       a = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
        2:       a = {1'b1, 31'($urandom)};
        default: a = 32'($urandom_range(0, 63));
      endcase
      we = 1'($urandom);
      re = ($urandom_range(0, 7) != 0);
      access(we, re, a, $urandom, 4'($urandom));
    end

    repeat (3) access(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
